// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package ysyx_22040125_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RRESP,
    S_WREQ,
    S_WRESP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  // Byte-lane strobe for an access of 2^size bytes starting at lane off.
  function automatic logic [7:0] size_mask(input size_e size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [2:0] off,
                                         input int unsigned xlen);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return (xlen == 32) || (|off);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_if.sv
// Split read/write data-bus channels between the LSU (master) and memory (slave).
interface ysyx_22040125_lsu_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BYTES = XLEN / 8;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_size;
  logic              rd_resp_valid;
  logic [XLEN-1:0]   rd_resp_data;
  logic              rd_resp_err;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [BYTES-1:0]  wr_strb;
  logic [2:0]        wr_size;
  logic              wr_resp_valid;
  logic              wr_resp_err;

  modport master (
    output rd_req_valid, rd_addr, rd_size, wr_req_valid, wr_addr, wr_data, wr_strb, wr_size,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err,
           wr_req_ready, wr_resp_valid, wr_resp_err
  );

  modport slave (
    input  rd_req_valid, rd_addr, rd_size, wr_req_valid, wr_addr, wr_data, wr_strb, wr_size,
    output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err,
           wr_req_ready, wr_resp_valid, wr_resp_err
  );
endinterface

// File: rtl/ysyx_22040125_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with extension.
module ysyx_22040125_lsu_align
  import ysyx_22040125_lsu_pkg::*;
#(
  parameter  int unsigned XLEN  = 64,
  localparam int unsigned BYTES = XLEN / 8,
  localparam int unsigned OFFW  = $clog2(BYTES)
) (
  input  logic [XLEN-1:0]  st_data,
  input  logic [OFFW-1:0]  st_off,
  input  size_e            st_size,
  output logic [XLEN-1:0]  st_lane_data,
  output logic [BYTES-1:0] st_strb,
  input  logic [XLEN-1:0]  ld_raw,
  input  logic [OFFW-1:0]  ld_off,
  input  size_e            ld_size,
  input  logic             ld_unsigned,
  output logic [XLEN-1:0]  ld_data
);

  logic [7:0]      st_mask;
  logic [7:0]      ld_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    st_lane_data = st_data << {st_off, 3'b000};
    st_mask      = size_mask(st_size, 3'(st_off));
    st_strb      = st_mask[BYTES-1:0];

    shifted = ld_raw >> {ld_off, 3'b000};
    ld_mask = size_mask(ld_size, 3'b000);
    keep    = '0;
    sign    = 1'b0;
    // The highest kept lane supplies the sign bit.
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (ld_mask[b]) begin
        keep[8*b +: 8] = 8'hFF;
        sign           = shifted[8*b+7];
      end
    end
    ld_data = (shifted & keep) | ((sign && !ld_unsigned) ? ~keep : '0);
  end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Multi-cycle MEM-stage load/store unit: request FSM, bus handshakes, result hold across stalls.
module ysyx_22040125_lsu
  import ysyx_22040125_lsu_pkg::*;
#(
  parameter int unsigned       XLEN      = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [XLEN-1:0]     mem_wdata,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic                stall_other,
  output logic                stall_mem,
  output logic [XLEN-1:0]     mem_rdata,
  output logic                load_misalign,
  output logic                store_misalign,
  output logic                access_fault,
  ysyx_22040125_lsu_if.master bus
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              uns_q;
  logic [OFFW-1:0]   off_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BYTES-1:0]  strb_q;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;

  size_e             req_size;
  logic [OFFW-1:0]   req_off;
  logic [ADDR_W-1:0] rel_addr;
  logic              req_misaligned;
  logic              accept;
  logic [XLEN-1:0]   lane_data;
  logic [BYTES-1:0]  lane_strb;
  logic [XLEN-1:0]   ld_data;

  assign req_size       = size_e'(mem_size);
  assign req_off        = mem_addr[OFFW-1:0];
  assign rel_addr       = mem_addr - BASE_ADDR;
  assign req_misaligned = is_misaligned(req_size, 3'(req_off), XLEN);

  ysyx_22040125_lsu_align #(.XLEN(XLEN)) u_align (
    .st_data      (mem_wdata),
    .st_off       (req_off),
    .st_size      (req_size),
    .st_lane_data (lane_data),
    .st_strb      (lane_strb),
    .ld_raw       (bus.rd_resp_data),
    .ld_off       (off_q),
    .ld_size      (size_q),
    .ld_unsigned  (uns_q),
    .ld_data      (ld_data)
  );

  always_comb begin
    state_d        = state_q;
    stall_mem      = 1'b0;
    load_misalign  = 1'b0;
    store_misalign = 1'b0;
    accept         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A simultaneous load and store request resolves to the store.
        if (mem_wen || mem_ren) begin
          if (req_misaligned) begin
            store_misalign = mem_wen;
            load_misalign  = !mem_wen;
          end else begin
            accept    = 1'b1;
            stall_mem = 1'b1;
            state_d   = mem_wen ? S_WREQ : S_RREQ;
          end
        end
      end
      S_RREQ: begin
        stall_mem = 1'b1;
        if (bus.rd_req_ready) state_d = S_RRESP;
      end
      S_RRESP: begin
        stall_mem = 1'b1;
        if (bus.rd_resp_valid) state_d = S_DONE;
      end
      S_WREQ: begin
        stall_mem = 1'b1;
        if (bus.wr_req_ready) state_d = S_WRESP;
      end
      S_WRESP: begin
        stall_mem = 1'b1;
        if (bus.wr_resp_valid) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall_other) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {rel_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        size_q  <= req_size;
        uns_q   <= mem_unsigned;
        off_q   <= req_off;
        wdata_q <= lane_data;
        strb_q  <= lane_strb;
      end
      case (state_q)
        S_RRESP: if (bus.rd_resp_valid) begin
          rdata_q <= bus.rd_resp_err ? '0 : ld_data;
          fault_q <= bus.rd_resp_err;
        end
        S_WRESP: if (bus.wr_resp_valid) fault_q <= bus.wr_resp_err;
        S_DONE: if (!stall_other) begin
          rdata_q <= '0;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_rdata        = rdata_q;
  assign access_fault     = fault_q;
  assign bus.rd_req_valid = (state_q == S_RREQ);
  assign bus.wr_req_valid = (state_q == S_WREQ);
  assign bus.rd_addr      = addr_q;
  assign bus.wr_addr      = addr_q;
  assign bus.rd_size      = {1'b0, size_q};
  assign bus.wr_size      = {1'b0, size_q};
  assign bus.wr_data      = wdata_q;
  assign bus.wr_strb      = strb_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Randomised bench for the LSU against a byte-array memory model; the bench acts as bus slave.
module tb_ysyx_22040125_lsu;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int unsigned MEMSZ  = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_ren = 1'b0;
  logic              mem_wen = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [XLEN-1:0]   mem_wdata = '0;
  logic [1:0]        mem_size = '0;
  logic              mem_unsigned = 1'b0;
  logic              stall_other = 1'b0;
  logic              stall_mem;
  logic [XLEN-1:0]   mem_rdata;
  logic              load_misalign;
  logic              store_misalign;
  logic              access_fault;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  mem [MEMSZ];

  ysyx_22040125_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  ysyx_22040125_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .stall_other    (stall_other),
    .stall_mem      (stall_mem),
    .mem_rdata      (mem_rdata),
    .load_misalign  (load_misalign),
    .store_misalign (store_misalign),
    .access_fault   (access_fault),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.rd_req_ready  = 1'b0;
    bus.rd_resp_valid = 1'b0;
    bus.rd_resp_data  = '0;
    bus.rd_resp_err   = 1'b0;
    bus.wr_req_ready  = 1'b0;
    bus.wr_resp_valid = 1'b0;
    bus.wr_resp_err   = 1'b0;
  endtask

  function automatic logic [63:0] word_at(input int unsigned a);
    logic [63:0] w;
    for (int unsigned b = 0; b < 8; b++) w[8*b +: 8] = mem[(a & ~32'd7) + b];
    return w;
  endfunction

  function automatic logic [63:0] load_model(input int unsigned a, input int unsigned n, input bit uns);
    logic [63:0] v;
    v = '0;
    for (int unsigned b = 0; b < n; b++) v[8*b +: 8] = mem[a + b];
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check(tag, {59'd0, stall_mem, load_misalign, store_misalign, access_fault,
                bus.rd_req_valid | bus.wr_req_valid}, 64'd0);
    check(tag, 64'(mem_rdata) | 64'(bus.rd_addr) | 64'(bus.wr_addr) | 64'(bus.wr_data)
               | 64'(bus.wr_strb) | 64'(bus.rd_size) | 64'(bus.wr_size), 64'd0);
  endtask

  task automatic run_op(input bit st, input bit both, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [63:0] wd, input int unsigned rdy_dly,
                        input int unsigned rsp_dly, input bit err, input int unsigned hold);
    int unsigned a, n, off, stalls;
    logic [63:0] exp_rd, lane, exp_wd;
    logic [7:0]  exp_strb;
    bit          mis;
    a    = addr - BASE;
    n    = 32'd1 << size;
    off  = a % 8;
    mis  = (a % n) != 0;
    @(negedge clk);
    mem_ren = !st || both; mem_wen = st; mem_addr = addr; mem_size = size;
    mem_unsigned = uns; mem_wdata = wd;
    #1;
    if (mis) begin
      if (st) check("store_misalign", 64'(store_misalign), 64'd1);
      else    check("load_misalign", 64'(load_misalign), 64'd1);
      check("misalign_stall", 64'(stall_mem), 64'd0);
      check("misalign_noreq", 64'({bus.rd_req_valid, bus.wr_req_valid}), 64'd0);
      @(negedge clk);
      mem_ren = 1'b0; mem_wen = 1'b0;
      #1;
      check("misalign_idle", 64'({stall_mem, bus.rd_req_valid, bus.wr_req_valid}), 64'd0);
      return;
    end
    check("accept_stall", 64'(stall_mem), 64'd1);
    stalls = 32'(stall_mem);
    @(negedge clk);
    mem_ren = 1'b0; mem_wen = 1'b0; mem_wdata = {$urandom, $urandom};
    #1;
    exp_strb = '0; exp_wd = '0; lane = '0;
    for (int unsigned b = 0; b < n; b++) begin
      exp_strb[off + b]         = 1'b1;
      lane[8*(off + b) +: 8]    = 8'hFF;
      exp_wd[8*(off + b) +: 8]  = wd[8*b +: 8];
    end
    for (int unsigned i = 0; i <= rdy_dly; i++) begin
      stalls += 32'(stall_mem);
      if (st) begin
        check("wr_req_valid", 64'({bus.wr_req_valid, bus.rd_req_valid}), 64'd2);
        check("wr_addr", 64'(bus.wr_addr), 64'(a & ~32'd7));
        check("wr_size", 64'(bus.wr_size), 64'(size));
        check("wr_strb", 64'(bus.wr_strb), 64'(exp_strb));
        check("wr_data", bus.wr_data & lane, exp_wd);
      end else begin
        check("rd_req_valid", 64'({bus.rd_req_valid, bus.wr_req_valid}), 64'd2);
        check("rd_addr", 64'(bus.rd_addr), 64'(a & ~32'd7));
        check("rd_size", 64'(bus.rd_size), 64'(size));
      end
      if (i == rdy_dly) begin
        if (st) bus.wr_req_ready = 1'b1;
        else    bus.rd_req_ready = 1'b1;
      end else begin
        // Early responses must not be taken while the request is pending.
        bus.rd_resp_valid = 1'($urandom % 2);
        bus.rd_resp_data  = {$urandom, $urandom};
        bus.rd_resp_err   = 1'b1;
        bus.wr_resp_valid = 1'($urandom % 2);
        bus.wr_resp_err   = 1'b1;
      end
      @(negedge clk);
      bus_idle();
      #1;
    end
    for (int unsigned i = 0; i <= rsp_dly; i++) begin
      stalls += 32'(stall_mem);
      check("req_dropped", 64'({bus.rd_req_valid, bus.wr_req_valid}), 64'd0);
      if (i == rsp_dly) begin
        if (st) begin
          bus.wr_resp_valid = 1'b1; bus.wr_resp_err = err;
        end else begin
          bus.rd_resp_valid = 1'b1; bus.rd_resp_err = err;
          bus.rd_resp_data  = err ? {$urandom, $urandom} : word_at(a);
        end
      end else if (st) begin
        bus.rd_resp_valid = 1'b1; bus.rd_resp_err = 1'b1;
      end else begin
        bus.wr_resp_valid = 1'b1; bus.wr_resp_err = 1'b1;
      end
      @(negedge clk);
      bus_idle();
      #1;
    end
    exp_rd = (st || err) ? 64'd0 : load_model(a, n, uns);
    if (st && !err) for (int unsigned b = 0; b < n; b++) mem[a + b] = wd[8*b +: 8];
    check("stall_cycles", 64'(stalls), 64'(3 + rdy_dly + rsp_dly));
    check("done_stall", 64'(stall_mem), 64'd0);
    check("mem_rdata", mem_rdata, exp_rd);
    check("access_fault", 64'(access_fault), 64'(err));
    stall_other = (hold != 0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("hold_rdata", mem_rdata, exp_rd);
      check("hold_fault", 64'(access_fault), 64'(err));
      check("hold_noreq", 64'({stall_mem, bus.rd_req_valid, bus.wr_req_valid}), 64'd0);
      stall_other = (i + 1 < hold);
    end
    @(negedge clk);
    #1;
    check("idle_clear", mem_rdata | 64'(access_fault) | 64'(stall_mem), 64'd0);
  endtask

  initial begin
    bus_idle();
    for (int unsigned i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // lw: sign-extended upper word of a 64-bit beat
    for (int unsigned b = 0; b < 8; b++) mem[32'h100 + b] = 8'(64'h8765_4321_0000_0000 >> (8*b));
    run_op(1'b0, 1'b0, 32'h8000_0104, 2'd2, 1'b0, '0, 0, 0, 1'b0, 0);
    check("lw_value", load_model(32'h104, 4, 1'b0), 64'hFFFF_FFFF_8765_4321);
    // sb to top lane with a slow write-ready
    run_op(1'b1, 1'b0, 32'h8000_0007, 2'd0, 1'b0, 64'hAB, 4, 0, 1'b0, 0);
    // misaligned lh / sd
    run_op(1'b0, 1'b0, 32'h8000_0003, 2'd1, 1'b0, '0, 0, 0, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'h8000_0004, 2'd3, 1'b0, 64'h1234, 0, 0, 1'b0, 0);
    // lbu with and without bus error
    mem[2] = 8'hF0;
    run_op(1'b0, 1'b0, 32'h8000_0002, 2'd0, 1'b1, '0, 0, 0, 1'b1, 0);
    run_op(1'b0, 1'b0, 32'h8000_0002, 2'd0, 1'b1, '0, 0, 0, 1'b0, 0);
    // load held in DONE by an external stall
    run_op(1'b0, 1'b0, 32'h8000_0010, 2'd3, 1'b0, '0, 1, 2, 1'b0, 3);
    // ren and wen together: store only
    run_op(1'b1, 1'b1, 32'h8000_0020, 2'd2, 1'b0, 64'hDEAD_BEEF, 0, 1, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'h8000_0020, 2'd2, 1'b1, '0, 0, 0, 1'b0, 0);

    // Reset while waiting in RRESP
    @(negedge clk);
    mem_ren = 1'b1; mem_addr = 32'h8000_0108; mem_size = 2'd3; mem_unsigned = 1'b0;
    @(negedge clk);
    mem_ren = 1'b0; bus.rd_req_ready = 1'b1;
    @(negedge clk);
    bus_idle();
    #1;
    check("pre_reset_stall", 64'(stall_mem), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.rd_resp_valid = 1'b1; bus.rd_resp_err = 1'b1; bus.rd_resp_data = '1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_idle();
    #1;
    check("stale_resp_ignored", mem_rdata | 64'(access_fault) | 64'(stall_mem), 64'd0);
    run_op(1'b1, 1'b0, 32'h8000_0030, 2'd2, 1'b0, 64'h0BAD_F00D, 0, 0, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'h8000_0030, 2'd2, 1'b0, '0, 0, 0, 1'b0, 0);

    for (int unsigned k = 0; k < 300; k++) begin
      int unsigned ra, rs;
      rs = $urandom % 4;
      ra = $urandom % (MEMSZ - 8);
      if ($urandom % 4 != 0) ra = ra & ~((32'd1 << rs) - 1);
      run_op(1'($urandom % 2), 1'b0, BASE + ra, 2'(rs), 1'($urandom % 2),
             {$urandom, $urandom}, $urandom % 4, $urandom % 4,
             ($urandom % 8) == 0, $urandom % 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_lsu.md
Name: ysyx_22040125_lsu

Overview:
- Parametrised, multi-cycle load/store unit for the MEM stage of the RV core.
- Replaces the purely combinational memory-stage glue with a registered FSM: valid/ready request handshake towards the data bus, byte-lane alignment of write data, strobe generation, lane extraction plus sign/zero extension of read data.
- Adds misalignment and bus-error reporting and holds results across external pipeline stalls.

Parameters:
- XLEN, 64, data width in bits (32 or 64); BYTES = XLEN/8, OFFW = log2(BYTES).
- ADDR_W, 32, address width.
- BASE_ADDR, 32'h8000_0000, subtracted from the core address before it goes on the bus.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_ren  in  1  load request from pipeline.
- mem_wen  in  1  store request from pipeline.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  XLEN  store data, LSB-justified.
- mem_size  in  2  0=B 1=H 2=W 3=D.
- mem_unsigned  in  1  zero-extend the load.
- stall_other  in  1  another stage holds the pipeline.
- stall_mem  out  1  MEM stage not finished.
- mem_rdata  out  XLEN  extended load result.
- load_misalign  out  1  load exception flag.
- store_misalign  out  1  store exception flag.
- access_fault  out  1  bus error flag.
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  read request accepted.
- rd_addr  out  ADDR_W  read bus address.
- rd_size  out  3  log2 bytes.
- rd_resp_valid  in  1  read data valid.
- rd_resp_data  in  XLEN  read data.
- rd_resp_err  in  1  read error.
- wr_req_valid  out  1  write request valid.
- wr_req_ready  in  1  write request accepted.
- wr_addr  out  ADDR_W  write bus address.
- wr_data  out  XLEN  write data, lane-shifted.
- wr_strb  out  BYTES  write byte strobes.
- wr_size  out  3  log2 bytes.
- wr_resp_valid  in  1  write complete.
- wr_resp_err  in  1  write error.

Behaviour:
- Reset: state IDLE; every output 0; the latched request and data are cleared. Reset mid-transaction abandons the transfer immediately; the bus side discards any stale response.
- States: IDLE, RREQ, RRESP, WREQ, WRESP, DONE.
- Request qualification in IDLE:
  - req = mem_ren | mem_wen. If both are high, the store wins and the read is ignored.
  - off = mem_addr[OFFW-1:0].
  - misaligned = off not a multiple of 2^mem_size, or mem_size=3 with XLEN=32.
- IDLE, req, aligned:
  - Latch addr, size, unsigned, off.
  - Latch wdata << 8*off and strb = ((1<<2^size)-1) << off.
  - Go to RREQ or WREQ.
  - stall_mem = 1 combinationally in this cycle.
- IDLE, req, misaligned: no bus transaction. load_misalign or store_misalign is driven combinationally in the same cycle, stall_mem = 0, state stays IDLE.
- IDLE, no req: stall_mem = 0.
- Bus addresses: rd_addr/wr_addr = (addr - BASE_ADDR) with the low OFFW bits cleared, registered. rd_size/wr_size = latched size.
- RREQ: rd_req_valid = 1 until rd_req_ready is sampled high, then go to RRESP. valid must not drop before ready.
- RRESP: on rd_resp_valid, go to DONE.
  - mem_rdata is registered from rd_resp_data >> 8*off, truncated to the access size, then sign- or zero-extended to XLEN per unsigned.
  - access_fault is registered from rd_resp_err; mem_rdata = 0 when the error is set.
- WREQ/WRESP: the same handshake on wr_req_valid/wr_req_ready, then wait for wr_resp_valid, then DONE. access_fault = wr_resp_err.
- stall_mem: 1 in RREQ, RRESP, WREQ, WRESP. 0 in DONE.
- DONE: mem_rdata and access_fault are stable.
  - If stall_other = 0, go to IDLE next cycle; flags and data clear there.
  - If stall_other = 1, remain in DONE holding outputs, and do not re-issue the request.
- Minimum load latency with an immediately ready bus and a response one cycle after acceptance: 3 stalled cycles (IDLE, RREQ, RRESP), result in cycle 4.
- rd_resp_valid or wr_resp_valid arriving in a state that does not expect it is ignored.
- Bus responses arriving while in RREQ/WREQ are not accepted.

Decomposition:
- Shared package ysyx_22040125_lsu_pkg holds:
  - state enum (6 states, 3-bit);
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - functions size_mask(size, off) → strobe and is_misaligned(size, off, xlen).
- One natural sub-module, ysyx_22040125_lsu_align: combinational write-lane shift and strobe generation, plus read-lane extraction and extension.
- FSM, latches and handshakes stay in the top module.

Test Plan:
- XLEN=64, lw addr 0x8000_0104, bus ready at once, resp one cycle later with data 0x8765_4321_0000_0000 → rd_addr 0x100, rd_size 2, stall high 3 cycles, mem_rdata 0xFFFF_FFFF_8765_4321.
- sb addr 0x8000_0007, wdata 0xAB → wr_addr 0x0, wr_strb 0x80, wr_data[63:56]=0xAB; wr_req_ready delayed 4 cycles → wr_req_valid held stable throughout.
- lh addr 0x8000_0003 → load_misalign=1 same cycle, stall_mem=0, no rd_req_valid. sd addr 0x8000_0004 → store_misalign=1.
- lbu addr 0x8000_0002, resp data byte2=0xF0, rd_resp_err=1 → access_fault=1, mem_rdata=0. Repeat with err=0 → 0xF0.
- Load completes with stall_other=1 for 3 cycles → state stays DONE, mem_rdata held, exactly one rd_req_valid handshake.
- rst_n pulsed low while in RRESP → all outputs 0 asynchronously, IDLE. A following sw completes normally. ren=wen=1 → write only.
